// File: rtl/sifh_hist_engine_if.sv
// ---------------------------------------------------------------------------
// sifh_hist_engine_if
//   Bundles the frame control, TDC event stream, histogram RAM port and peak
//   report of sifh_hist_engine.
//   master : the histogram engine (drives ev_ready, RAM address/enables/data,
//            peak report, busy, done)
//   slave  : the environment (drives start, events, RAM read data)
//   Signals:
//     start                        frame start pulse
//     ev_valid/ev_ready            event handshake
//     ev_data[TDC_W], ev_pix[PIX_W] event timestamp and pixel
//     ram_raddr/ram_re/ram_rdata   RAM read port (1-cycle latency)
//     ram_waddr/ram_we/ram_wdata   RAM write port
//     peak_valid/pix/bin/cnt       per-pixel peak report
//     busy, done                   frame status
// ---------------------------------------------------------------------------
interface sifh_hist_engine_if #(
   parameter int TDC_W = 12,
   parameter int BIN_W = 8,
   parameter int PIX_W = 2,
   parameter int CNT_W = 8
);
   localparam int AW = PIX_W + BIN_W;

   logic             start;
   logic             ev_valid;
   logic             ev_ready;
   logic [TDC_W-1:0] ev_data;
   logic [PIX_W-1:0] ev_pix;
   logic [AW-1:0]    ram_raddr;
   logic             ram_re;
   logic [CNT_W-1:0] ram_rdata;
   logic [AW-1:0]    ram_waddr;
   logic             ram_we;
   logic [CNT_W-1:0] ram_wdata;
   logic             peak_valid;
   logic [PIX_W-1:0] peak_pix;
   logic [BIN_W-1:0] peak_bin;
   logic [CNT_W-1:0] peak_cnt;
   logic             busy;
   logic             done;

   modport master (
      input  start, ev_valid, ev_data, ev_pix, ram_rdata,
      output ev_ready, ram_raddr, ram_re, ram_waddr, ram_we, ram_wdata,
             peak_valid, peak_pix, peak_bin, peak_cnt, busy, done
   );

   modport slave (
      output start, ev_valid, ev_data, ev_pix, ram_rdata,
      input  ev_ready, ram_raddr, ram_re, ram_waddr, ram_we, ram_wdata,
             peak_valid, peak_pix, peak_bin, peak_cnt, busy, done
   );
endinterface

// File: rtl/sifh_hist_engine.sv
// ---------------------------------------------------------------------------
// sifh_hist_engine
//   Multi-pixel TDC histogram engine. Per frame it clears the histogram RAM,
//   accumulates EV_NUM events at one per clock (read-modify-write with
//   forwarding of the previous write, saturating counters), then scans every
//   pixel's bins and reports the peak bin of each pixel.
//
//   Ports:
//     clk   clock
//     res   asynchronous active-low reset
//     bus   sifh_hist_engine_if.master (events, RAM port, peak report, status)
//
//   Optional build macro SIFH_CLEAR_ON_READ_EN: the PEAK scan writes 0 behind
//   each bin it reads, so CLEAR only runs for the first frame after reset.
// ---------------------------------------------------------------------------
module sifh_hist_engine #(
   parameter int TDC_W  = 12,
   parameter int BIN_W  = 8,
   parameter int PIX_W  = 2,
   parameter int CNT_W  = 8,
   parameter int EV_NUM = 1024
) (
   input logic                clk,
   input logic                res,
   sifh_hist_engine_if.master bus
);
   localparam int AW   = PIX_W + BIN_W;
   localparam int EC_W = $clog2(EV_NUM + 1);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLEAR = 3'd1;
   localparam logic [2:0] S_ACC   = 3'd2;
   localparam logic [2:0] S_DRAIN = 3'd3;
   localparam logic [2:0] S_PEAK  = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;

   logic [2:0]       state, state_nxt;
   logic [AW-1:0]    addr_cnt;      // CLEAR write address / PEAK read address
   logic [EC_W-1:0]  ev_cnt;

   // Accumulate pipeline: stage 2 holds the address read last cycle,
   // wr_* remembers the write stage 2 made the cycle before.
   logic             s2_valid;
   logic [AW-1:0]    s2_addr;
   logic             wr_valid;
   logic [AW-1:0]    wr_addr;
   logic [CNT_W-1:0] wr_data;

   // Peak scan: rd_* is the bin whose data arrives this cycle.
   logic             rd_valid;
   logic [AW-1:0]    rd_addr;
   logic [CNT_W-1:0] max_cnt;
   logic [BIN_W-1:0] max_bin;

   logic             peak_valid_q;
   logic [PIX_W-1:0] peak_pix_q;
   logic [BIN_W-1:0] peak_bin_q;
   logic [CNT_W-1:0] peak_cnt_q;

   logic             accept, peak_re, last_cmp, clear_needed;
   logic [AW-1:0]    ev_addr;
   logic [BIN_W-1:0] rd_bin;
   logic [CNT_W-1:0] old_cnt, inc_cnt, cand_cnt;
   logic [BIN_W-1:0] cand_bin;

   assign ev_addr  = {bus.ev_pix, bus.ev_data[TDC_W-1 -: BIN_W]};
   assign accept   = (state == S_ACC) && bus.ev_valid;
   assign rd_bin   = rd_addr[BIN_W-1:0];
   // The cycle that compares the very last bin issues no further read.
   assign last_cmp = rd_valid && (&rd_addr);
   assign peak_re  = (state == S_PEAK) && !last_cmp;

   // Timestamp LSBs below the bin field are deliberately ignored.
   if (TDC_W > BIN_W) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^bus.ev_data[TDC_W-BIN_W-1:0];
   end

   // Back-to-back hits on one bin: RAM still holds the stale value, so take
   // the count written last cycle instead.
   assign old_cnt = (wr_valid && (wr_addr == s2_addr)) ? wr_data : bus.ram_rdata;
   assign inc_cnt = (&old_cnt) ? old_cnt : old_cnt + CNT_W'(1);

   // Bin 0 of a pixel always loads; later bins only win if strictly greater.
   always_comb begin
      // NOTE: defaults first so every path assigns every output (no latch).
      cand_cnt = max_cnt;
      cand_bin = max_bin;
      if ((rd_bin == '0) || (bus.ram_rdata > max_cnt)) begin
         cand_cnt = bus.ram_rdata;
         cand_bin = rd_bin;
      end
   end

`ifdef SIFH_CLEAR_ON_READ_EN
   logic cleared_once;
   assign clear_needed = !cleared_once;

   always_ff @(posedge clk or negedge res) begin
      if (!res)                                   cleared_once <= 1'b0;
      else if ((state == S_CLEAR) && (&addr_cnt)) cleared_once <= 1'b1;
   end
`else
   assign clear_needed = 1'b1;
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (bus.start) state_nxt = clear_needed ? S_CLEAR : S_ACC;
         S_CLEAR: if (&addr_cnt) state_nxt = S_ACC;
         S_ACC:   if (accept && (ev_cnt == EC_W'(EV_NUM - 1))) state_nxt = S_DRAIN;
         S_DRAIN: state_nxt = S_PEAK;
         S_PEAK:  if (last_cmp) state_nxt = S_DONE;
         S_DONE:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // NOTE: the histogram RAM is external and never reset; CLEAR zeroes it.
   always_ff @(posedge clk or negedge res) begin
      if (!res) begin
         state        <= S_IDLE;
         addr_cnt     <= '0;
         ev_cnt       <= '0;
         s2_valid     <= 1'b0;
         s2_addr      <= '0;
         wr_valid     <= 1'b0;
         wr_addr      <= '0;
         wr_data      <= '0;
         rd_valid     <= 1'b0;
         rd_addr      <= '0;
         max_cnt      <= '0;
         max_bin      <= '0;
         peak_valid_q <= 1'b0;
         peak_pix_q   <= '0;
         peak_bin_q   <= '0;
         peak_cnt_q   <= '0;
      end else begin
         // NOTE: non-blocking so every register sees pre-edge values.
         state <= state_nxt;

         if ((state == S_CLEAR) || peak_re) addr_cnt <= addr_cnt + AW'(1);

         if (state == S_IDLE) ev_cnt <= '0;
         else if (accept)     ev_cnt <= ev_cnt + EC_W'(1);

         s2_valid <= accept;
         if (accept) s2_addr <= ev_addr;

         wr_valid <= s2_valid;
         if (s2_valid) begin
            wr_addr <= s2_addr;
            wr_data <= inc_cnt;
         end

         rd_valid <= peak_re;
         if (peak_re) rd_addr <= addr_cnt;

         if (rd_valid) begin
            max_cnt <= cand_cnt;
            max_bin <= cand_bin;
         end

         peak_valid_q <= rd_valid && (&rd_bin);
         if (rd_valid && (&rd_bin)) begin
            peak_pix_q <= rd_addr[AW-1:BIN_W];
            peak_bin_q <= cand_bin;
            peak_cnt_q <= cand_cnt;
         end
      end
   end

   always_comb begin
      bus.ram_re    = 1'b0;
      bus.ram_raddr = '0;
      bus.ram_we    = 1'b0;
      bus.ram_waddr = '0;
      bus.ram_wdata = '0;
      if (accept) begin
         bus.ram_re    = 1'b1;
         bus.ram_raddr = ev_addr;
      end else if (peak_re) begin
         bus.ram_re    = 1'b1;
         bus.ram_raddr = addr_cnt;
      end
      if (state == S_CLEAR) begin
         bus.ram_we    = 1'b1;
         bus.ram_waddr = addr_cnt;
      end else if (s2_valid) begin
         bus.ram_we    = 1'b1;
         bus.ram_waddr = s2_addr;
         bus.ram_wdata = inc_cnt;
      end
`ifdef SIFH_CLEAR_ON_READ_EN
      else if (rd_valid) begin
         // Zero the bin whose data is being compared this cycle.
         bus.ram_we    = 1'b1;
         bus.ram_waddr = rd_addr;
      end
`endif
   end

   assign bus.ev_ready   = (state == S_ACC);
   assign bus.busy       = (state != S_IDLE);
   assign bus.done       = (state == S_DONE);
   assign bus.peak_valid = peak_valid_q;
   assign bus.peak_pix   = peak_pix_q;
   assign bus.peak_bin   = peak_bin_q;
   assign bus.peak_cnt   = peak_cnt_q;

endmodule

// File: tb/tb_sifh_hist_engine.sv
// ---------------------------------------------------------------------------
// tb_sifh_hist_engine
//   Self-checking bench for sifh_hist_engine with a behavioural 1-cycle
//   read-latency RAM. Expected per-pixel peaks are computed from the event
//   list when a frame is driven and queued; each peak_valid pulse pops and
//   compares one entry. Frame-level counts (busy length, accepted events,
//   RAM writes, done pulses, CLEAR sweep) are compared at frame end.
// ---------------------------------------------------------------------------
module tb_sifh_hist_engine;
   localparam int TDC_W  = 12;
   localparam int BIN_W  = 8;
   localparam int PIX_W  = 2;
   localparam int CNT_W  = 4;
   localparam int EV_NUM = 20;
   localparam int AW     = PIX_W + BIN_W;
   localparam int DEPTH  = 1 << AW;
   localparam int NPIX   = 1 << PIX_W;
   localparam int NBIN   = 1 << BIN_W;
   localparam int CMAX   = (1 << CNT_W) - 1;
   localparam int FRAME_LIMIT = 3 * DEPTH + 500;
`ifdef SIFH_CLEAR_ON_READ_EN
   localparam bit COR = 1'b1;
`else
   localparam bit COR = 1'b0;
`endif

   typedef struct packed {
      logic [PIX_W-1:0] pix;
      logic [BIN_W-1:0] bin;
      logic [CNT_W-1:0] cnt;
   } peak_t;

   logic clk = 1'b0;
   logic res;
   int   tests = 0;
   int   fails = 0;
   bit   cleared;

   peak_t            exp_q[$];
   logic [PIX_W-1:0] ev_pix_l [EV_NUM];
   logic [BIN_W-1:0] ev_bin_l [EV_NUM];
   int               gap_l    [EV_NUM];
   logic [CNT_W-1:0] mem      [DEPTH];

   sifh_hist_engine_if #(.TDC_W(TDC_W), .BIN_W(BIN_W), .PIX_W(PIX_W), .CNT_W(CNT_W)) bus ();

   sifh_hist_engine #(
      .TDC_W(TDC_W), .BIN_W(BIN_W), .PIX_W(PIX_W), .CNT_W(CNT_W), .EV_NUM(EV_NUM)
   ) u_dut (
      .clk (clk),
      .res (res),
      .bus (bus.master)
   );

   always #5 clk = ~clk;

   // Simple dual-port RAM, read-before-write, one-cycle read latency.
   always @(posedge clk) begin
      if (bus.ram_we) mem[bus.ram_waddr] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_raddr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int sat(input int v);
      return (v > CMAX) ? CMAX : v;
   endfunction

   function automatic int count_of(input logic [PIX_W-1:0] p, input logic [BIN_W-1:0] b);
      int n = 0;
      for (int i = 0; i < EV_NUM; i++)
         if (ev_pix_l[i] == p && ev_bin_l[i] == b) n++;
      return sat(n);
   endfunction

   // Reference model: saturated histogram, lowest bin wins ties.
   task automatic push_expect();
      int    hist [NPIX][NBIN];
      int    best, best_bin;
      peak_t e;
      for (int p = 0; p < NPIX; p++)
         for (int b = 0; b < NBIN; b++) hist[p][b] = 0;
      for (int i = 0; i < EV_NUM; i++) hist[ev_pix_l[i]][ev_bin_l[i]]++;
      for (int p = 0; p < NPIX; p++) begin
         best     = sat(hist[p][0]);
         best_bin = 0;
         for (int b = 1; b < NBIN; b++)
            if (sat(hist[p][b]) > best) begin
               best     = sat(hist[p][b]);
               best_bin = b;
            end
         e.pix = PIX_W'(p);
         e.bin = BIN_W'(best_bin);
         e.cnt = CNT_W'(best);
         exp_q.push_back(e);
      end
   endtask

   task automatic set_ev(input int i, input int p, input int b, input int g);
      ev_pix_l[i] = PIX_W'(p);
      ev_bin_l[i] = BIN_W'(b);
      gap_l[i]    = g;
   endtask

   task automatic gen_random();
      int sel;
      for (int i = 0; i < EV_NUM; i++) begin
         sel = $urandom_range(0, 5);
         set_ev(i, $urandom_range(0, NPIX - 1),
                (sel == 0) ? 0 : (sel == 1) ? NBIN - 1 : (sel == 2) ? NBIN - 2
                           : $urandom_range(0, 7),
                (i > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0);
      end
   endtask

   // Drives one frame cycle by cycle: inputs change 1 time unit after the
   // rising edge, outputs are sampled on the falling edge.
   task automatic run_frame(input bit clear_exp, input int abort_after, input bit poke_start,
                            input logic [AW-1:0] probe_addr, input int probe_cnt);
      int    idx = 0, gap = gap_l[0], busy_cyc = 0, hs = 0, wr = 0, dn = 0;
      int    clr_bad = 0, stall = 0, tail = -1, since_hs = -1, peak_seen = 0;
      bit    finished = 1'b0;
      peak_t e;
      @(posedge clk); #1;
      for (int cyc = 0; cyc < FRAME_LIMIT && !finished; cyc++) begin
         bus.start = (cyc == 0) || (poke_start && idx == 5);
         if (idx < EV_NUM && gap > 0) begin
            bus.ev_valid = 1'b0;
         end else begin
            bus.ev_valid = 1'b1;
            bus.ev_pix   = (idx < EV_NUM) ? ev_pix_l[idx] : '0;
            bus.ev_data  = (idx < EV_NUM) ? {ev_bin_l[idx], (TDC_W-BIN_W)'($urandom)} : '0;
         end
         @(negedge clk);
         if (bus.busy) begin
            if (clear_exp && busy_cyc < DEPTH &&
                !(bus.ram_we && bus.ram_wdata == '0 && bus.ram_waddr == AW'(busy_cyc)))
               clr_bad++;
            busy_cyc++;
         end
         if (bus.ram_we) wr++;
         if (since_hs >= 0) since_hs++;
         if (bus.ev_valid && bus.ev_ready) begin
            hs++;
            idx++;
            gap = (idx < EV_NUM) ? gap_l[idx] : 0;
            if (hs == EV_NUM) since_hs = 0;
         end else if (bus.ev_ready) begin
            stall++;
            if (gap > 0) gap--;
         end
         // First PEAK cycle: the final accumulate write has landed.
         if (since_hs == 2 && probe_cnt >= 0) check("ram_word", mem[probe_addr], probe_cnt);
         if (bus.done) begin
            dn++;
            if (tail < 0) tail = 3;
         end
         if (bus.peak_valid) begin
            peak_seen++;
            if (exp_q.size() > 0) begin
               e = exp_q.pop_front();
               check("peak_pix", bus.peak_pix, e.pix);
               check("peak_bin", bus.peak_bin, e.bin);
               check("peak_cnt", bus.peak_cnt, e.cnt);
            end
         end
         if (abort_after >= 0 && hs == abort_after) begin
            #2 res = 1'b0;
            #1;
            check("rst_mid_ctrl", {bus.ev_ready, bus.ram_re, bus.ram_we, bus.peak_valid,
                                   bus.busy, bus.done}, 0);
            check("rst_mid_peak", {bus.peak_pix, bus.peak_bin, bus.peak_cnt}, 0);
            check("rst_mid_ram", {bus.ram_raddr, bus.ram_waddr}, 0);
            exp_q.delete();
            bus.ev_valid = 1'b0;
            bus.start    = 1'b0;
            @(negedge clk);
            res     = 1'b1;
            cleared = 1'b0;
            return;
         end
         if (tail == 0) finished = 1'b1;
         else if (tail > 0) tail--;
         @(posedge clk); #1;
      end
      bus.ev_valid = 1'b0;
      bus.start    = 1'b0;
      check("frame_done", finished, 1);
      check("busy_cycles", busy_cyc, (clear_exp ? DEPTH : 0) + EV_NUM + stall + 1 + DEPTH + 2);
      check("accepted", hs, EV_NUM);
      check("ram_writes", wr, (clear_exp ? DEPTH : 0) + EV_NUM + (COR ? DEPTH : 0));
      check("done_pulses", dn, 1);
      check("clear_sweep_bad", clr_bad, 0);
      check("peak_pulses", peak_seen, NPIX);
      cleared = 1'b1;
   endtask

   initial begin
      res          = 1'b0;
      cleared      = 1'b0;
      bus.start    = 1'b0;
      bus.ev_valid = 1'b0;
      bus.ev_data  = '0;
      bus.ev_pix   = '0;
      repeat (2) @(negedge clk);
      bus.start    = 1'b1;
      bus.ev_valid = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_ctrl", {bus.ev_ready, bus.ram_re, bus.ram_we, bus.peak_valid, bus.busy,
                         bus.done}, 0);
      check("rst_addr", {bus.ram_raddr, bus.ram_waddr}, 0);
      check("rst_data", {bus.ram_wdata, bus.peak_pix, bus.peak_bin, bus.peak_cnt}, 0);
      bus.start    = 1'b0;
      bus.ev_valid = 1'b0;
      res          = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_no_start", bus.busy, 0);

      // Frame 1: pixel 1 peak at bin 5 (3 hits), pixel 3 bin 2 saturates.
      for (int i = 0; i < EV_NUM; i++) set_ev(i, 3, 2, 0);
      set_ev(0, 1, 5, 0);
      set_ev(9, 1, 5, 0);
      set_ev(10, 1, 9, 0);
      set_ev(19, 1, 5, 0);
      push_expect();
      run_frame(!COR || !cleared, -1, 1'b0, {2'd3, 8'd2}, count_of(2'd3, 8'd2));

      // Frame 2: back-to-back hits on {2,17}, tie resolution, last bin,
      // input gaps and a start pulse during ACC.
      for (int i = 0; i < 4; i++) set_ev(i, 2, 17, 0);
      set_ev(4, 0, 3, 2);
      set_ev(5, 0, 7, 0);
      set_ev(6, 0, 3, 0);
      set_ev(7, 0, 7, 0);
      for (int i = 8; i < 11; i++) set_ev(i, 3, 200, (i == 10) ? 1 : 0);
      for (int i = 11; i < 14; i++) set_ev(i, 3, 100, 0);
      set_ev(14, 1, 0, 0);
      for (int i = 15; i < 20; i++) set_ev(i, 1, 255, (i == 15) ? 3 : 0);
      push_expect();
      run_frame(!COR || !cleared, -1, 1'b1, {2'd2, 8'd17}, count_of(2'd2, 8'd17));

      // Frame 3: reset in the middle of accumulation.
      gen_random();
      run_frame(!COR || !cleared, 7, 1'b0, '0, -1);

      // Frames 4 and 5: random traffic; frame 4 must clear again after reset.
      for (int f = 0; f < 2; f++) begin
         gen_random();
         push_expect();
         run_frame(!COR || !cleared, -1, 1'b0, {ev_pix_l[0], ev_bin_l[0]},
                   count_of(ev_pix_l[0], ev_bin_l[0]));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
